// File: rtl/note_sequencer_if.sv
// Control/status bundle between a player front end and the note sequencer.
interface note_sequencer_if;
  logic [7:0] key;   // piano keys, level; key[i] requests note code i+1
  logic       play;  // pulse: start auto-play
  logic       stop;  // pulse: abort auto-play
  logic       loop;  // level: restart the song at its end
  logic [3:0] note;  // 0 = silence, 1..8 = DO..high DO
  logic       busy;  // auto-play active (also while frozen)
  logic [3:0] step;  // current song ROM index
  logic       done;  // one-cycle pulse at song end when loop=0

  modport master (
    output key, play, stop, loop,
    input  note, busy, step, done
  );

  modport slave (
    input  key, play, stop, loop,
    output note, busy, step, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Auto-play note sequencer: walks a 16-entry song ROM producing tone/gap
// timing, lets manual keys freeze and override the song, and returns to
// the exact remaining duration when the keys are released.
module note_sequencer #(
  parameter int BEAT_CYCLES = 250000,  // clk cycles per beat
  parameter int GAP_CYCLES  = 25000    // silent cycles at the end of each note
) (
  input  logic             clk,
  input  logic             rst_n,
  note_sequencer_if.slave  bus
);

  // Counters must hold the longest note (4 beats) without overflow.
  localparam int CNT_W = $clog2(4 * BEAT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TONE   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FREEZE = 2'd3;

  localparam logic [3:0]       END_CODE = 4'd15;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  // Song ROM, each entry {code, len}; a note lasts len+1 beats.
  localparam logic [5:0] SONG_ROM [0:15] = '{
    {4'd1, 2'd0}, {4'd1, 2'd0}, {4'd5, 2'd0}, {4'd5, 2'd0},
    {4'd6, 2'd0}, {4'd6, 2'd0}, {4'd5, 2'd1}, {4'd4, 2'd0},
    {4'd4, 2'd0}, {4'd3, 2'd0}, {4'd3, 2'd0}, {4'd2, 2'd0},
    {4'd2, 2'd0}, {4'd1, 2'd1}, {END_CODE, 2'd0}, {END_CODE, 2'd0}
  };

  // Counters count down to zero, so they are loaded with duration-1.
  function automatic logic [CNT_W-1:0] tone_load(input logic [1:0] len);
    tone_load = CNT_W'((int'(len) + 1) * BEAT_CYCLES - GAP_CYCLES - 1);
  endfunction

  // Lowest pressed key wins.
  function automatic logic [3:0] key_note(input logic [7:0] k);
    key_note = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) key_note = 4'(i + 1);
    end
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       r_saved;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_step;
  logic [3:0]       r_note;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [1:0]       w_saved_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_step_nxt;
  logic [3:0]       w_note_nxt;
  logic             w_done_nxt;

  logic             w_key_any;
  logic [3:0]       w_key_note;
  logic [3:0]       w_cur_code;
  logic [3:0]       w_enter_idx;
  logic             w_end_hit;
  logic             w_finish;
  logic [3:0]       w_start_idx;
  logic [3:0]       w_start_code;
  logic [1:0]       w_start_len;
  logic [1:0]       w_run_state;
  logic             w_enter;

  assign w_key_any  = |bus.key;
  assign w_key_note = key_note(bus.key);
  assign w_cur_code = SONG_ROM[r_step][5:2];

  // Entry about to start: entry 0 from IDLE (step is 0 there), otherwise the next one.
  // An end marker with loop set is replaced by entry 0 in the same cycle.
  always_comb begin
    w_enter_idx  = (r_state == S_IDLE) ? r_step : r_step + 4'd1;
    w_end_hit    = (SONG_ROM[w_enter_idx][5:2] == END_CODE);
    w_finish     = w_end_hit && !bus.loop;
    w_start_idx  = w_end_hit ? 4'd0 : w_enter_idx;
    w_start_code = SONG_ROM[w_start_idx][5:2];
    w_start_len  = SONG_ROM[w_start_idx][1:0];
  end

  // Next-state logic; releasing FREEZE runs the saved state's normal cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_saved_nxt = r_saved;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_note_nxt  = r_note;
    w_done_nxt  = 1'b0;
    w_enter     = 1'b0;
    w_run_state = (r_state == S_FREEZE) ? r_saved : r_state;

    if (bus.stop && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_step_nxt  = 4'd0;
      w_note_nxt  = w_key_note;
    end else if (r_state == S_IDLE) begin
      w_note_nxt = w_key_note;
      w_enter    = bus.play;
    end else if (w_key_any) begin
      // Keys override auto-play; counters and step hold.
      w_state_nxt = S_FREEZE;
      if (r_state != S_FREEZE) w_saved_nxt = r_state;
      w_note_nxt  = w_key_note;
    end else if (w_run_state == S_TONE) begin
      if (r_cnt == '0) begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = GAP_LOAD;
        w_note_nxt  = 4'd0;
      end else begin
        w_state_nxt = S_TONE;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_note_nxt  = w_cur_code;
      end
    end else begin
      if (r_cnt == '0) begin
        w_enter = 1'b1;
      end else begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_note_nxt  = 4'd0;
      end
    end

    if (w_enter) begin
      if (w_finish) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_step_nxt  = 4'd0;
        w_note_nxt  = 4'd0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_TONE;
        w_cnt_nxt   = tone_load(w_start_len);
        w_step_nxt  = w_start_idx;
        w_note_nxt  = w_start_code;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= 4'd0;
      r_note  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_note  <= w_note_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.note = r_note;
  assign bus.busy = r_busy;
  assign bus.step = r_step;
  assign bus.done = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  note_sequencer_if u_if ();

  note_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    u_if.key = 8'd0; u_if.play = 1'b0; u_if.stop = 1'b0; u_if.loop = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_note", u_if.note, 8'd0);
    chk("rst_busy", u_if.busy, 8'd0);
    chk("rst_step", u_if.step, 8'd0);
    chk("rst_done", u_if.done, 8'd0);
    tickn(2);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", u_if.busy, 8'd0);

    // Full song, no keys; play sampled at edge k
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    chk("e0_note_k", u_if.note, 8'd1);
    chk("e0_busy_k", u_if.busy, 8'd1);
    chk("e0_step_k", u_if.step, 8'd0);
    tickn(7);  chk("e0_note_k7", u_if.note, 8'd1);
    tick();    chk("e0_gap_k8", u_if.note, 8'd0);
    tick();    chk("e0_gap_k9", u_if.note, 8'd0);
    tick();    chk("e1_note_k10", u_if.note, 8'd1);
               chk("e1_step_k10", u_if.step, 8'd1);
    tickn(8);  chk("e1_gap_k18", u_if.note, 8'd0);
    tickn(2);  chk("e2_note_k20", u_if.note, 8'd5);
               chk("e2_step_k20", u_if.step, 8'd2);
    tickn(40); chk("e6_note_k60", u_if.note, 8'd5);
               chk("e6_step_k60", u_if.step, 8'd6);
    tickn(17); chk("e6_note_k77", u_if.note, 8'd5);
    tick();    chk("e6_gap_k78", u_if.note, 8'd0);
    tickn(62); chk("e13_note_k140", u_if.note, 8'd1);
               chk("e13_step_k140", u_if.step, 8'd13);
    tickn(17); chk("e13_note_k157", u_if.note, 8'd1);
    tick();    chk("e13_gap_k158", u_if.note, 8'd0);
    tickn(2);  chk("end_done", u_if.done, 8'd1);
               chk("end_busy", u_if.busy, 8'd0);
               chk("end_note", u_if.note, 8'd0);
               chk("end_step", u_if.step, 8'd0);
    tick();    chk("end_done_clr", u_if.done, 8'd0);

    // Loop: entry 13 gap end jumps straight to entry 0
    u_if.loop = 1'b1;
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    tickn(159); chk("loop_step_k159", u_if.step, 8'd13);
                chk("loop_note_k159", u_if.note, 8'd0);
    tick();     chk("loop_note_k160", u_if.note, 8'd1);
                chk("loop_step_k160", u_if.step, 8'd0);
                chk("loop_busy_k160", u_if.busy, 8'd1);
                chk("loop_done_k160", u_if.done, 8'd0);
    tick();     chk("loop_done_k161", u_if.done, 8'd0);

    // stop together with play during TONE acts as stop
    u_if.stop = 1'b1; u_if.play = 1'b1; tick();
    u_if.stop = 1'b0; u_if.play = 1'b0;
    chk("sp_busy", u_if.busy, 8'd0);
    chk("sp_note", u_if.note, 8'd0);
    chk("sp_step", u_if.step, 8'd0);
    u_if.loop = 1'b0;

    // stop in IDLE has no effect
    u_if.stop = 1'b1; tick(); u_if.stop = 1'b0;
    chk("stop_idle_busy", u_if.busy, 8'd0);

    // Freeze 3 cycles into entry 0, key held for 5 edges
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    tickn(2);
    u_if.key = 8'b0000_0100; tick();
    chk("frz_note", u_if.note, 8'd3);
    chk("frz_busy", u_if.busy, 8'd1);
    tickn(4);
    chk("frz_note_hold", u_if.note, 8'd3);
    chk("frz_step_hold", u_if.step, 8'd0);
    u_if.key = 8'd0; tick();
    chk("rel_note_r", u_if.note, 8'd1);
    tickn(4); chk("rel_note_r4", u_if.note, 8'd1);
    tick();   chk("rel_gap_r5", u_if.note, 8'd0);
    tickn(2); chk("rel_e1_note", u_if.note, 8'd1);
              chk("rel_e1_step", u_if.step, 8'd1);

    // play while busy is ignored
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    chk("pb_note", u_if.note, 8'd1);
    chk("pb_step", u_if.step, 8'd1);
    chk("pb_busy", u_if.busy, 8'd1);
    u_if.stop = 1'b1; tick(); u_if.stop = 1'b0;
    chk("stop_busy", u_if.busy, 8'd0);

    // Key priority in IDLE: lowest index wins
    u_if.key = 8'b1000_0010; tick();
    chk("prio_note", u_if.note, 8'd2);
    chk("prio_busy", u_if.busy, 8'd0);
    u_if.key = 8'd0; tick();
    chk("prio_rel_note", u_if.note, 8'd0);
    chk("prio_rel_busy", u_if.busy, 8'd0);

    // Asynchronous reset mid-GAP at entry 5
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    tickn(58);
    chk("pre_rst_step", u_if.step, 8'd5);
    chk("pre_rst_busy", u_if.busy, 8'd1);
    rst_n = 1'b0; #1;
    chk("arst_busy", u_if.busy, 8'd0);
    chk("arst_step", u_if.step, 8'd0);
    chk("arst_note", u_if.note, 8'd0);
    chk("arst_done", u_if.done, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    u_if.play = 1'b1; tick(); u_if.play = 1'b0;
    chk("post_rst_note", u_if.note, 8'd1);
    chk("post_rst_step", u_if.step, 8'd0);
    chk("post_rst_busy", u_if.busy, 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- BEAT_CYCLES, 250000, clk cycles per beat.
- GAP_CYCLES, 25000, silent cycles at the end of each auto note; legal range 1..BEAT_CYCLES-1.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- key  input  8  piano keys, level; key[i] requests note code i+1.
- play  input  1  single-cycle pulse; starts auto-play.
- stop  input  1  single-cycle pulse; aborts auto-play.
- loop  input  1  level; 1 = restart the song at its end.
- note  output  4  note code to tone datapath; 0 = silence, 1..8 = DO..high DO.
- busy  output  1  auto-play active, including while frozen.
- step  output  4  current song ROM index.
- done  output  1  one-cycle pulse at song end when loop=0.

Function
REQ-003 Internal song ROM SHALL be 16 entries of {code[3:0], len[1:0]}; beats = len+1.
REQ-004 ROM contents (code/beats) SHALL be, entries 0-13: 1/1, 1/1, 5/1, 5/1, 6/1, 6/1, 5/2, 4/1, 4/1, 3/1, 3/1, 2/1, 2/1, 1/2; entries 14-15: code 15, the end marker.
REQ-005 The sequencer SHALL use states IDLE, TONE, GAP and FREEZE.
REQ-006 Transitions SHALL be:
- IDLE->TONE on play.
- TONE->GAP when the tone counter expires.
- GAP->TONE at the next entry when the gap counter expires.
- TONE/GAP->FREEZE while any key is high.
- FREEZE->the saved state when all keys are low.
- Any state->IDLE on stop.
REQ-007 Tone length SHALL be beats*BEAT_CYCLES-GAP_CYCLES cycles with note=code, followed by GAP_CYCLES cycles with note=0.
REQ-008 Tone and gap counters SHALL be wide enough for 4*BEAT_CYCLES with no overflow.
REQ-009 On entering TONE, the ROM entry SHALL be examined.
- Code 15 with loop=0: go to IDLE, pulse done, step=0.
- Code 15 with loop=1: jump to entry 0 in the same cycle and play it with no extra silence.
REQ-010 step SHALL increment modulo 16 after each GAP; wrap from 15 to 0 is legal.
REQ-011 In IDLE or FREEZE, note SHALL equal the lowest index i with key[i]=1, plus 1; it SHALL be 0 if no key is high. Manual keys have priority over auto-play.
REQ-012 In FREEZE, counters and step SHALL hold their values; on return, the remaining duration SHALL resume unchanged.
REQ-013 Outputs note, busy, step and done SHALL be registered, with one cycle latency from an input change (play, stop, key) to the output.
REQ-014 play SHALL be ignored when busy=1.
REQ-015 stop together with play SHALL act as stop.
REQ-016 stop in IDLE SHALL have no effect.
REQ-017 A key change within FREEZE SHALL update note only.
REQ-018 A key rising in the same cycle as a counter expiry SHALL take FREEZE first; the expiry SHALL be processed after release.
REQ-019 busy SHALL be 1 in TONE, GAP and FREEZE, and 0 in IDLE.

Reset
REQ-020 While rst_n=0, regardless of clk, the outputs SHALL be: note=0, busy=0, step=0, done=0. State SHALL be IDLE and counters SHALL be 0.
REQ-021 Deassertion SHALL take effect at the next clk edge.
REQ-022 Reset mid-song SHALL discard all progress; play afterwards SHALL start at entry 0.

Verification (BEAT_CYCLES=10, GAP_CYCLES=2)
REQ-023 The bench SHALL cover these directed scenarios:
- Play, no keys: play pulse at edge k -> note=1 for cycles k+1..k+8, 0 for 2 cycles, 1 for 8, 0 for 2, then 5; entry 6 gives note=5 for 18 cycles; after entry 13, done=1 for one cycle, busy=0, note=0, step=0.
- loop=1: entry 13 gap ends -> note=1 with step=0 in the next cycle; busy stays 1; done never pulses.
- Freeze: key=8'b0000_0100 held 5 cycles, 3 cycles into entry 0 -> note=3 one cycle later, step frozen; after release, note=1 for the remaining 5 cycles, then gap.
- Priority: key=8'b1000_0010 in IDLE -> note=2; after release -> note=0; busy stays 0.
- stop and play in the same cycle during TONE -> IDLE, note=0, busy=0, step=0; play while busy -> no change.
- rst_n low mid-GAP at entry 5 -> outputs 0 immediately, without a clk edge; a later play starts at entry 0 with note=1.
